// File: rtl/alu_muldiv.sv
// Single-cycle ALU with an iterative multiply/divide unit that writes a HI/LO register pair.
// Multiply and divide each take WIDTH shift-add or restoring-subtract steps on operand magnitudes.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] operand0,
  input  logic [WIDTH-1:0] operand1,
  input  logic [SHW-1:0]   shamt,
  input  logic [3:0]       control,
  input  logic             start,
  input  logic             hi_wr,
  input  logic             lo_wr,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   dvs;
  logic [WIDTH-1:0]   op0_q;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               dbz_q;

  // ---------------- combinational ALU ----------------
  logic [WIDTH-1:0] sum_ab;
  logic [WIDTH-1:0] diff_ab;

  assign sum_ab  = operand0 + operand1;
  assign diff_ab = operand0 - operand1;

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (control)
      4'd0:  result = operand0 & operand1;
      4'd1:  result = operand0 | operand1;
      4'd2:  result = operand0 ^ operand1;
      4'd3:  result = ~(operand0 | operand1);
      4'd4:  result = sum_ab;
      4'd5: begin
        result   = sum_ab;
        overflow = (operand0[WIDTH-1] == operand1[WIDTH-1]) &&
                   (sum_ab[WIDTH-1] != operand0[WIDTH-1]);
      end
      4'd6:  result = diff_ab;
      4'd7: begin
        result   = diff_ab;
        overflow = (operand0[WIDTH-1] != operand1[WIDTH-1]) &&
                   (diff_ab[WIDTH-1] != operand0[WIDTH-1]);
      end
      4'd8:  result = {{(WIDTH-1){1'b0}}, ($signed(operand0) < $signed(operand1))};
      4'd9:  result = operand1 << shamt;
      4'd10: result = operand1 >> shamt;
      4'd11: result = WIDTH'($signed(operand1) >>> shamt);
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

  // ---------------- iterative multiply / divide ----------------
  logic             accept;
  logic             sgn;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  assign accept = start && (control[3:2] == 2'b11) && (state == IDLE);
  assign sgn    = ~control[0];
  assign a_neg  = sgn & operand0[WIDTH-1];
  assign b_neg  = sgn & operand1[WIDTH-1];
  assign abs_a  = a_neg ? (~operand0 + 1'b1) : operand0;
  assign abs_b  = b_neg ? (~operand1 + 1'b1) : operand1;

  // prod holds {partial product, multiplier} for multiply and {remainder, quotient} for divide
  logic [WIDTH:0]     mac;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] next_prod;

  always_comb begin
    mac     = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, dvs} : '0);
    shifted = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    trial   = shifted - {1'b0, dvs};
    if (!is_div)
      next_prod = {mac, prod[WIDTH-1:1]};
    else if (trial[WIDTH])
      next_prod = {shifted[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
    else
      next_prod = {trial[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
  end

  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign prod_neg = ~prod + 1'b1;
  assign quo_fix  = neg_q ? (~prod[WIDTH-1:0] + 1'b1) : prod[WIDTH-1:0];
  assign rem_fix  = neg_r ? (~prod[2*WIDTH-1:WIDTH] + 1'b1) : prod[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      prod        <= '0;
      dvs         <= '0;
      op0_q       <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dbz_q       <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state  <= CALC;
            cnt    <= '0;
            is_div <= control[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            dbz_q  <= control[1] && (operand1 == '0);
            op0_q  <= operand0;
            if (control[1]) begin
              prod <= {{WIDTH{1'b0}}, abs_a};
              dvs  <= abs_b;
            end else begin
              prod <= {{WIDTH{1'b0}}, abs_b};
              dvs  <= abs_a;
            end
          end else begin
            if (hi_wr) hi <= operand0;
            if (lo_wr) lo <= operand0;
          end
        end
        CALC: begin
          prod <= next_prod;
          cnt  <= cnt + 1'b1;
          if (cnt == '1) state <= FIX;
        end
        FIX: begin
          state <= IDLE;
          done  <= 1'b1;
          if (!is_div) begin
            {hi, lo} <= neg_q ? prod_neg : prod;
          end else if (dbz_q) begin
            hi          <= op0_q;
            lo          <= '1;
            div_by_zero <= 1'b1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv at WIDTH=32: combinational ops,
// multiply/divide results and latency, ignored commands, HI/LO writes and mid-op reset.
module tb_alu_muldiv;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] operand0;
  logic [WIDTH-1:0] operand1;
  logic [SHW-1:0]   shamt;
  logic [3:0]       control;
  logic             start;
  logic             hi_wr;
  logic             lo_wr;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  int errors = 0;
  int checks = 0;
  int n;
  int done_seen;

  alu_muldiv #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk(clk), .reset(reset), .operand0(operand0), .operand1(operand1),
    .shamt(shamt), .control(control), .start(start), .hi_wr(hi_wr), .lo_wr(lo_wr),
    .result(result), .zero(zero), .overflow(overflow), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic alu(input string tag, input logic [3:0] c, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] sh,
                     input logic [31:0] exp_res, input logic exp_ov, input logic exp_zero);
    @(negedge clk);
    control = c; operand0 = a; operand1 = b; shamt = sh;
    #1;
    check({tag, "_res"}, 64'(result), 64'(exp_res));
    check({tag, "_ov"}, 64'(overflow), 64'(exp_ov));
    check({tag, "_zero"}, 64'(zero), 64'(exp_zero));
  endtask

  task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_dbz);
    int k;
    @(negedge clk);
    control = c; operand0 = a; operand1 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_start"}, 64'(busy), 64'd1);
    k = 0;
    while (!done && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_latency"}, 64'(k), 64'(WIDTH + 1));
    check({tag, "_busy_done"}, 64'(busy), 64'd0);
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    check({tag, "_dbz"}, 64'(div_by_zero), 64'(exp_dbz));
  endtask

  initial begin
    reset = 1'b1; operand0 = '0; operand1 = '0; shamt = '0; control = '0;
    start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    alu("and",   4'd0,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0,  32'h00F0_00F0, 1'b0, 1'b0);
    alu("or",    4'd1,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0,  32'hFFF0_FFF0, 1'b0, 1'b0);
    alu("xor",   4'd2,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0,  32'hFF00_FF00, 1'b0, 1'b0);
    alu("nor",   4'd3,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0,  32'h000F_000F, 1'b0, 1'b0);
    alu("addu",  4'd4,  32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000, 1'b0, 1'b0);
    alu("adds",  4'd5,  32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000, 1'b1, 1'b0);
    alu("adds0", 4'd5,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b0, 1'b1);
    alu("sub0",  4'd6,  32'h0000_0005, 32'h0000_0005, 5'd0,  32'h0000_0000, 1'b0, 1'b1);
    alu("subs1", 4'd7,  32'h8000_0000, 32'h0000_0001, 5'd0,  32'h7FFF_FFFF, 1'b1, 1'b0);
    alu("subs2", 4'd7,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd0,  32'h8000_0000, 1'b1, 1'b0);
    alu("subs3", 4'd7,  32'h0000_0003, 32'h0000_0005, 5'd0,  32'hFFFF_FFFE, 1'b0, 1'b0);
    alu("slt1",  4'd8,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0001, 1'b0, 1'b0);
    alu("slt0",  4'd8,  32'h0000_0001, 32'hFFFF_FFFF, 5'd0,  32'h0000_0000, 1'b0, 1'b1);
    alu("sll",   4'd9,  32'h0,         32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1'b0);
    alu("srl",   4'd10, 32'h0,         32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0, 1'b0);
    alu("sra",   4'd11, 32'h0,         32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0, 1'b0);
    alu("mulop", 4'd12, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd0,  32'h0000_0000, 1'b0, 1'b1);

    // start with an ALU code must not launch anything
    @(negedge clk);
    control = 4'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("alu_start_ignored", 64'(busy), 64'd0);

    @(negedge clk);
    operand0 = 32'h0000_1234; lo_wr = 1'b1;
    @(posedge clk); #1;
    lo_wr = 1'b0;
    check("lo_wr_idle", 64'(lo), 64'h1234);
    @(negedge clk);
    operand0 = 32'h0000_5678; hi_wr = 1'b1;
    @(posedge clk); #1;
    hi_wr = 1'b0;
    check("hi_wr_idle", 64'(hi), 64'h5678);
    check("hi_wr_lo_hold", 64'(lo), 64'h1234);

    run_op("mult",   4'd12, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op("multu",  4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("div",    4'd14, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_nd", 4'd14, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    run_op("divu0",  4'd15, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 1'b1);
    run_op("divmin", 4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op("divu",   4'd15, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0);

    // start and HI/LO writes while busy must be ignored
    @(negedge clk);
    control = 4'd13; operand0 = 32'd6; operand1 = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      if (n == 9) begin
        @(negedge clk);
        control = 4'd14; operand0 = 32'h0000_DEAD; operand1 = 32'd3;
        start = 1'b1; lo_wr = 1'b1; hi_wr = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0; lo_wr = 1'b0; hi_wr = 1'b0;
      n++;
    end
    check("busy_latency", 64'(n), 64'(WIDTH + 1));
    check("busy_hi", 64'(hi), 64'd0);
    check("busy_lo", 64'(lo), 64'd42);
    @(posedge clk); #1;
    check("done_one_cycle", 64'(done), 64'd0);
    check("no_second_op", 64'(busy), 64'd0);

    // reset in the middle of a divide aborts it
    @(negedge clk);
    control = 4'd15; operand0 = 32'd100; operand1 = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_hi", 64'(hi), 64'd0);
    check("mid_rst_lo", 64'(lo), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    check("mid_rst_no_done", 64'(done_seen), 64'd0);
    run_op("after_rst", 4'd15, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set operand, result, HI and LO width (legal: 8..64, power of two).
REQ-002 Parameter SHW, default $clog2(WIDTH), SHALL set shamt width.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 operand0  in  WIDTH  first operand; also dividend, multiplicand, MTHI/MTLO data.
REQ-006 operand1  in  WIDTH  second operand; also divisor, multiplier, shift source.
REQ-007 shamt  in  SHW  shift amount.
REQ-008 control  in  4  operation select.
REQ-009 start  in  1  launch MULT/MULTU/DIV/DIVU when control is 12..15.
REQ-010 hi_wr, lo_wr  in  1 each  write operand0 into HI/LO (MTHI/MTLO).
REQ-011 result  out  WIDTH  combinational result.
REQ-012 zero  out  1  high when result == 0.
REQ-013 overflow  out  1  signed add/subtract overflow.
REQ-014 hi, lo  out  WIDTH  registered HI/LO contents.
REQ-015 busy  out  1  multi-cycle operation in progress.
REQ-016 done  out  1  one-cycle pulse, HI/LO just updated by a multi-cycle op.
REQ-017 div_by_zero  out  1  one-cycle pulse with done when divisor was 0.

Function
REQ-018 Control codes 0..11 SHALL be combinational, same cycle: 0 AND, 1 OR, 2 XOR, 3 NOR, 4 ADD, 5 signed ADD, 6 SUB, 7 signed SUB, 8 SLT (signed, result 1/0), 9 SLL, 10 SRL, 11 SRA; shifts apply shamt to operand1.
REQ-019 overflow SHALL be 1 only for codes 5/7 when operand signs imply a sign-incorrect result (add: like signs, result sign differs; sub: unlike signs, result sign differs from operand0); 0 for all other codes; result wraps modulo 2^WIDTH.
REQ-020 Codes 12 MULT, 13 MULTU, 14 DIV, 15 DIVU SHALL drive result = 0 (zero = 1, overflow = 0).
REQ-021 FSM states IDLE, CALC, FIX; busy = (state != IDLE).
REQ-022 IDLE -> CALC on edge where start=1 and control>=12; operands, control latched, iteration counter cleared.
REQ-023 start with control<12, or any start while busy, SHALL be ignored with no state change.
REQ-024 CALC SHALL perform one shift-add (multiply) or restoring-subtract (divide) step per cycle on operand magnitudes (signed ops) or raw operands (unsigned), exactly WIDTH steps, then -> FIX.
REQ-025 FIX -> IDLE SHALL apply sign correction and write HI/LO; done=1 for the following cycle only.
REQ-026 Latency: start sampled at edge k -> HI/LO valid and done high after edge k+WIDTH+1 (33 edges at WIDTH=32); busy high after edge k through edge k+WIDTH+1.
REQ-027 Multiply: {HI,LO} = full 2*WIDTH product; MULT signed, MULTU unsigned.
REQ-028 Divide: LO = quotient truncated toward zero, HI = remainder with sign of dividend.
REQ-029 Signed most-negative / -1: LO = most-negative value, HI = 0, no flag.
REQ-030 Divisor 0: LO = all ones, HI = operand0, div_by_zero pulses with done.
REQ-031 New start accepted in the cycle done is high (state is IDLE).
REQ-032 hi_wr/lo_wr SHALL write HI/LO on the next edge only when IDLE and no accepted start; ignored while busy; accepted start takes priority over simultaneous hi_wr/lo_wr.
REQ-033 HI/LO SHALL hold value except on REQ-025 or REQ-032 writes.

Reset
REQ-034 reset=1 at an edge SHALL set state IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter 0, overriding start/hi_wr/lo_wr.
REQ-035 reset mid-operation SHALL abort: no done pulse, HI/LO = 0, new start accepted the cycle after reset deasserts.
REQ-036 Combinational outputs (result, zero, overflow) SHALL be unaffected by reset.

Verification (WIDTH=32)
REQ-037 MULT 0xFFFFFFFD x 0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1, done exactly 33 edges after start edge, busy low same cycle.
REQ-038 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; DIV 0xFFFFFFF9 / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-039 DIVU 7 / 0 -> lo=0xFFFFFFFF, hi=0x00000007, div_by_zero=1 with done; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-040 control 5, 0x7FFFFFFF + 1 -> result=0x80000000, overflow=1; control 11, operand1=0x80000000, shamt=4 -> 0xF8000000; control 6, 5-5 -> zero=1.
REQ-041 start MULT while busy (cycle 10) -> ignored, original result only; lo_wr while busy -> LO unchanged; lo_wr 0x1234 when IDLE -> lo=0x1234 next cycle.
REQ-042 reset at cycle 15 of DIV -> next cycle busy=0, hi=lo=0, no done ever; start after release completes normally.
